// File: rtl/uart_bus_master.sv
// UART command bridge: parses 'W'/'R' frames from rxd, performs one 16-bit bus
// access through a req/ack arbiter, and returns '.', read data or '?' on txd.
//
// state    | meaning
// IDLE     | waiting for a command byte
// ADDR_H   | collecting address[15:8]
// ADDR_L   | collecting address[7:0]
// DATA_H   | collecting write data[15:8]
// DATA_L   | collecting write data[7:0]
// REQ      | bus_req high, waiting for bus_ack
// ACCESS   | bus_en cycle in progress
// REPLY    | handing reply bytes to the transmit holding register
module uart_bus_master #(
  parameter int CLKSPEED     = 32000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 2048
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        rxd,
  output logic        txd,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic        bus_en,
  output logic [15:0] address,
  output logic        rnw,
  output logic [15:0] dout,
  input  logic [15:0] din,
  output logic        busy
);

  localparam int DIV     = CLKSPEED / BAUD;
  localparam int TO_CLKS = TIMEOUT_BITS * DIV;
  localparam int BW      = $clog2(DIV + 1);
  localparam int TW      = $clog2(TO_CLKS + 1);
  localparam logic [BW-1:0] DIV_M1  = BW'(DIV - 1);
  localparam logic [BW-1:0] HALF_M1 = BW'(DIV / 2 - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TO_CLKS - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [2:0] {
    P_IDLE, P_ADDR_H, P_ADDR_L, P_DATA_H, P_DATA_L, P_REQ, P_ACCESS, P_REPLY
  } p_state_t;

  rx_state_t       rx_state;
  logic            rx_meta, rx_sync, rx_valid;
  logic [BW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;

  logic            tx_active, tx_full, tx_free, hold_wr;
  logic [7:0]      tx_hold;
  logic [8:0]      tx_shift;
  logic [3:0]      tx_bits;
  logic [BW-1:0]   tx_cnt;

  p_state_t        p_state;
  logic            is_read;
  logic [15:0]     addr_reg, data_reg, reply_buf;
  logic [1:0]      reply_cnt;
  logic [TW-1:0]   to_cnt;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_meta  <= rxd;
      rx_sync  <= rx_meta;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: if (!rx_sync) begin
          rx_state <= RX_START;
          rx_cnt   <= HALF_M1;
        end
        RX_START: if (rx_cnt == '0) begin
          if (rx_sync) rx_state <= RX_IDLE;  // glitch, not a real start bit
          else begin
            rx_state <= RX_DATA;
            rx_cnt   <= DIV_M1;
            rx_bit   <= '0;
          end
        end else rx_cnt <= rx_cnt - 1'b1;
        RX_DATA: if (rx_cnt == '0) begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_cnt   <= DIV_M1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
          else rx_bit <= rx_bit + 1'b1;
        end else rx_cnt <= rx_cnt - 1'b1;
        RX_STOP: if (rx_cnt == '0) begin
          if (rx_sync) begin
            rx_valid <= 1'b1;
            rx_state <= RX_IDLE;
          end else rx_state <= RX_WAIT;
        end else rx_cnt <= rx_cnt - 1'b1;
        RX_WAIT: if (rx_sync) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Shifter can take the next byte in the last clock of a stop bit, so
  // back-to-back replies are exactly 10*DIV clocks apart.
  assign tx_free = !tx_active || (tx_cnt == '0 && tx_bits == 4'd0);
  assign hold_wr = (p_state == P_REPLY) && !tx_full;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      txd       <= 1'b1;
      tx_active <= 1'b0;
      tx_full   <= 1'b0;
      tx_hold   <= '0;
      tx_shift  <= '0;
      tx_bits   <= '0;
      tx_cnt    <= '0;
    end else begin
      if (hold_wr) begin
        tx_hold <= reply_buf[15:8];
        tx_full <= 1'b1;
      end
      if (tx_free && tx_full) begin
        txd       <= 1'b0;
        tx_shift  <= {1'b1, tx_hold};
        tx_bits   <= 4'd9;
        tx_cnt    <= DIV_M1;
        tx_active <= 1'b1;
        tx_full   <= 1'b0;
      end else if (tx_active) begin
        if (tx_cnt == '0) begin
          if (tx_bits == 4'd0) tx_active <= 1'b0;
          else begin
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[8:1]};
            tx_bits  <= tx_bits - 1'b1;
            tx_cnt   <= DIV_M1;
          end
        end else tx_cnt <= tx_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      p_state   <= P_IDLE;
      is_read   <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      reply_buf <= '0;
      reply_cnt <= '0;
      to_cnt    <= '0;
      bus_req   <= 1'b0;
      bus_en    <= 1'b0;
      rnw       <= 1'b1;
      address   <= '0;
      dout      <= '0;
    end else begin
      bus_en <= 1'b0;
      case (p_state)
        P_IDLE: if (rx_valid) begin
          to_cnt <= TO_M1;
          if (rx_shift == 8'h57 || rx_shift == 8'h52) begin
            is_read <= (rx_shift == 8'h52);
            p_state <= P_ADDR_H;
          end else begin
            reply_buf <= 16'h3F00;
            reply_cnt <= 2'd1;
            p_state   <= P_REPLY;
          end
        end
        P_ADDR_H, P_ADDR_L, P_DATA_H, P_DATA_L: begin
          if (rx_valid) begin
            to_cnt <= TO_M1;
            case (p_state)
              P_ADDR_H: begin
                addr_reg[15:8] <= rx_shift;
                p_state        <= P_ADDR_L;
              end
              P_ADDR_L: begin
                addr_reg[7:0] <= rx_shift;
                if (is_read) begin
                  bus_req <= 1'b1;
                  p_state <= P_REQ;
                end else p_state <= P_DATA_H;
              end
              P_DATA_H: begin
                data_reg[15:8] <= rx_shift;
                p_state        <= P_DATA_L;
              end
              default: begin
                data_reg[7:0] <= rx_shift;
                bus_req       <= 1'b1;
                p_state       <= P_REQ;
              end
            endcase
          end else if (to_cnt == '0) p_state <= P_IDLE;
          else to_cnt <= to_cnt - 1'b1;
        end
        P_REQ: if (bus_ack) begin
          bus_en  <= 1'b1;
          address <= addr_reg;
          rnw     <= is_read;
          if (!is_read) dout <= data_reg;
          p_state <= P_ACCESS;
        end
        P_ACCESS: begin
          bus_req <= 1'b0;
          rnw     <= 1'b1;
          if (is_read) begin
            reply_buf <= din;
            reply_cnt <= 2'd2;
          end else begin
            reply_buf <= 16'h2E00;
            reply_cnt <= 2'd1;
          end
          p_state <= P_REPLY;
        end
        P_REPLY: if (!tx_full) begin
          reply_buf <= {reply_buf[7:0], 8'h00};
          reply_cnt <= reply_cnt - 1'b1;
          if (reply_cnt == 2'd1) p_state <= P_IDLE;
        end
        default: p_state <= P_IDLE;
      endcase
    end
  end

  assign busy = (p_state != P_IDLE) || tx_active || tx_full;

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: drives serial commands, answers the bus from a
// local memory, and checks bus cycles and serial replies against a command model.
module tb_uart_bus_master;
  localparam int CLKSPEED     = 1600;
  localparam int BAUD         = 100;
  localparam int TIMEOUT_BITS = 64;
  localparam int DIV          = CLKSPEED / BAUD;
  localparam int TO_CLKS      = TIMEOUT_BITS * DIV;

  logic        clk = 1'b0, reset_b = 1'b0, rxd = 1'b1, bus_ack = 1'b0;
  logic        txd, bus_req, bus_en, rnw, busy;
  logic [15:0] address, dout, din;

  typedef struct packed {
    logic [15:0] addr;
    logic        rnw;
    logic [15:0] data;
  } acc_t;

  logic [15:0] mem [0:255];
  logic [15:0] model_mem [0:255];
  logic [7:0]  cmd [$];
  logic [7:0]  exp_tx [$];
  acc_t        exp_acc [$];

  int total = 0, bad = 0, cyc = 0;
  int ack_delay = 0, acc_count = 0, req_cyc = 0, en_cyc = 0;
  bit stray_ack = 0;
  logic [15:0] last_addr = '0, last_dout = '0, last_tx = '0;
  logic        last_rnw = 1'b1;

  assign din = mem[address[7:0]];

  uart_bus_master #(.CLKSPEED(CLKSPEED), .BAUD(BAUD), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
    .clk(clk), .reset_b(reset_b), .rxd(rxd), .txd(txd), .bus_req(bus_req),
    .bus_ack(bus_ack), .bus_en(bus_en), .address(address), .rnw(rnw),
    .dout(dout), .din(din), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Command-level model: what the bridge must do for each correctly framed byte.
  task automatic model_rx(input logic [7:0] b);
    logic [15:0] a, v;
    if (cmd.size() == 0) begin
      if (b == 8'h57 || b == 8'h52) cmd.push_back(b);
      else exp_tx.push_back(8'h3F);
    end else begin
      cmd.push_back(b);
      if (cmd[0] == 8'h52 && cmd.size() == 3) begin
        a = {cmd[1], cmd[2]};
        v = model_mem[a[7:0]];
        exp_acc.push_back({a, 1'b1, 16'h0000});
        exp_tx.push_back(v[15:8]);
        exp_tx.push_back(v[7:0]);
        cmd.delete();
      end else if (cmd[0] == 8'h57 && cmd.size() == 5) begin
        a = {cmd[1], cmd[2]};
        v = {cmd[3], cmd[4]};
        exp_acc.push_back({a, 1'b0, v});
        model_mem[a[7:0]] = v;
        exp_tx.push_back(8'h2E);
        cmd.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop, input int gap);
    if (good_stop) model_rx(b);
    @(negedge clk) rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = good_stop;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (gap + 2) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
    chk("tx_drained", exp_tx.size(), 0);
    chk("acc_drained", exp_acc.size(), 0);
  endtask

  // Bus responder: grants ack_delay clocks after bus_req rises.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus_req) begin
        cnt = 0;
        bus_ack = stray_ack ? ($urandom_range(0, 3) == 0) : 1'b0;
      end else if (!bus_ack) begin
        if (cnt >= ack_delay) bus_ack = 1'b1;
        else cnt++;
      end
    end
  end

  // Per-cycle bus check: one bus_en exactly one clock after the first sampled
  // req&&ack, carrying the model's next expected access.
  initial begin
    bit pend = 0, granted = 0, after_en = 0, req_prev = 0;
    acc_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_b) begin
        pend = 0; granted = 0; after_en = 0; req_prev = 0;
      end else begin
        if (bus_req && !req_prev) req_cyc = cyc;
        req_prev = bus_req;
        chk("bus_en", {31'd0, bus_en}, {31'd0, pend});
        if (pend) granted = 1;
        if (after_en) begin
          chk("req_drop", {31'd0, bus_req}, 32'd0);
          chk("rnw_idle", {31'd0, rnw}, 32'd1);
        end
        after_en = bus_en;
        if (bus_en) begin
          en_cyc = cyc;
          acc_count++;
          if (exp_acc.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_access: got addr %h rnw %b want none", address, rnw);
          end else begin
            e = exp_acc.pop_front();
            chk("acc_addr", {16'd0, address}, {16'd0, e.addr});
            chk("acc_rnw", {31'd0, rnw}, {31'd0, e.rnw});
            if (!e.rnw) chk("acc_dout", {16'd0, dout}, {16'd0, e.data});
          end
          last_addr = address; last_rnw = rnw; last_dout = dout;
          if (!rnw) mem[address[7:0]] = dout;
        end
        if (!bus_req) granted = 0;
        pend = bus_req && bus_ack && !granted;
      end
    end
  end

  // Serial monitor: every bit of a reply frame must hold for exactly DIV clocks.
  initial begin
    logic [7:0] rb;
    logic cur;
    bit shape_ok, aborted;
    forever begin
      @(negedge clk);
      if (reset_b && !txd) begin
        shape_ok = 1; aborted = 0; rb = '0; cur = 1'b0;
        for (int c = 0; c < 10 * DIV; c++) begin
          if (c > 0) @(negedge clk);
          if (!reset_b) begin
            aborted = 1;
            break;
          end
          if (c % DIV == 0) begin
            cur = txd;
            if (c / DIV >= 1 && c / DIV <= 8) rb[c / DIV - 1] = txd;
          end else if (txd !== cur) shape_ok = 0;
          if (c / DIV == 0 && txd !== 1'b0) shape_ok = 0;
          if (c / DIV == 9 && txd !== 1'b1) shape_ok = 0;
        end
        if (!aborted) begin
          chk("tx_frame_shape", {31'd0, shape_ok}, 32'd1);
          if (exp_tx.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_tx: got %h want none", rb);
          end else chk("tx_byte", {24'd0, rb}, {24'd0, exp_tx.pop_front()});
          last_tx = {last_tx[7:0], rb};
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d want finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, d, last_w;
    int n, acc_before;
    for (int i = 0; i < 256; i++) begin
      d = 16'($urandom);
      mem[i] = d;
      model_mem[i] = d;
    end
    mem[8'h40] = 16'hBEEF;
    model_mem[8'h40] = 16'hBEEF;

    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_en", {31'd0, bus_en}, 32'd0);
    chk("rst_rnw", {31'd0, rnw}, 32'd1);
    chk("rst_address", {16'd0, address}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) #3 reset_b = 1'b1;
    repeat (5) @(negedge clk);

    // Write 0xABCD to 0x1234.
    ack_delay = 3;
    send_byte(8'h57, 1, 3); send_byte(8'h12, 1, 3); send_byte(8'h34, 1, 3);
    send_byte(8'hAB, 1, 3); send_byte(8'hCD, 1, 3);
    wait_idle(4000);
    chk("t1_addr", {16'd0, last_addr}, 32'h1234);
    chk("t1_rnw", {31'd0, last_rnw}, 32'd0);
    chk("t1_dout", {16'd0, last_dout}, 32'hABCD);
    chk("t1_reply", {24'd0, last_tx[7:0]}, 32'h2E);
    chk("t1_count", acc_count, 1);

    // Read 0x0040 -> BE EF.
    send_byte(8'h52, 1, 0); send_byte(8'h00, 1, 0); send_byte(8'h40, 1, 0);
    wait_idle(4000);
    chk("t2_addr", {16'd0, last_addr}, 32'h0040);
    chk("t2_rnw", {31'd0, last_rnw}, 32'd1);
    chk("t2_reply", {16'd0, last_tx}, 32'hBEEF);

    // Long arbitration wait.
    ack_delay = 500;
    send_byte(8'h52, 1, 0); send_byte(8'h12, 1, 0); send_byte(8'h40, 1, 0);
    wait_idle(6000);
    chk("t3_latency", en_cyc - req_cyc, 501);

    // Unknown command, then a read with a framing error in the middle.
    ack_delay = 1;
    send_byte(8'h41, 1, 0);
    wait_idle(2000);
    chk("t4_unknown", {24'd0, last_tx[7:0]}, 32'h3F);
    send_byte(8'h52, 1, 0); send_byte(8'h00, 0, 20);
    send_byte(8'h00, 1, 0); send_byte(8'h40, 1, 0);
    wait_idle(4000);
    chk("t4_addr", {16'd0, last_addr}, 32'h0040);
    chk("t4_reply", {16'd0, last_tx}, 32'hBEEF);

    // Mid-frame timeout, then a gap just under the timeout that must survive.
    acc_before = acc_count;
    send_byte(8'h57, 1, 0); send_byte(8'h12, 1, 0);
    chk("t5_busy_mid", {31'd0, busy}, 32'd1);
    repeat (TO_CLKS + 10) @(negedge clk);
    cmd.delete();
    chk("t5_busy_after", {31'd0, busy}, 32'd0);
    chk("t5_no_access", acc_count, acc_before);
    send_byte(8'h52, 1, TO_CLKS - 12 * DIV); send_byte(8'h00, 1, 0); send_byte(8'h40, 1, 0);
    wait_idle(4000);
    chk("t5_reply", {16'd0, last_tx}, 32'hBEEF);

    // Reset during a read reply.
    send_byte(8'h52, 1, 0); send_byte(8'h00, 1, 0); send_byte(8'h40, 1, 0);
    n = 0;
    while (txd && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reply_started", {31'd0, txd}, 32'd0);
    repeat (30) @(negedge clk);
    #3 reset_b = 1'b0;
    #1;
    chk("t6_txd", {31'd0, txd}, 32'd1);
    chk("t6_bus_req", {31'd0, bus_req}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    exp_tx.delete();
    cmd.delete();
    repeat (5) @(negedge clk);
    #3 reset_b = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h57, 1, 0); send_byte(8'h00, 1, 0); send_byte(8'h41, 1, 0);
    send_byte(8'h12, 1, 0); send_byte(8'h34, 1, 0);
    wait_idle(4000);
    send_byte(8'h52, 1, 0); send_byte(8'h00, 1, 0); send_byte(8'h41, 1, 0);
    wait_idle(4000);
    chk("t6_readback", {16'd0, last_tx}, 32'h1234);

    // Randomized command mix with stray acks while idle.
    stray_ack = 1;
    last_w = 16'h0041;
    for (int k = 0; k < 15; k++) begin
      int kind;
      kind = $urandom_range(0, 9);
      ack_delay = $urandom_range(0, 15);
      a = ($urandom_range(0, 1) == 0) ? last_w : 16'($urandom);
      d = 16'($urandom);
      if (kind < 2) begin
        logic [7:0] j;
        j = 8'($urandom);
        if (j == 8'h57 || j == 8'h52) j = 8'h00;
        send_byte(j, 1, $urandom_range(0, 20));
      end else if (kind < 6) begin
        send_byte(8'h57, 1, $urandom_range(0, 20));
        send_byte(a[15:8], 1, $urandom_range(0, 20));
        send_byte(a[7:0], 1, $urandom_range(0, 20));
        send_byte(d[15:8], 1, $urandom_range(0, 20));
        send_byte(d[7:0], 1, $urandom_range(0, 20));
        last_w = a;
      end else begin
        send_byte(8'h52, 1, $urandom_range(0, 20));
        send_byte(a[15:8], 1, $urandom_range(0, 20));
        send_byte(a[7:0], 1, $urandom_range(0, 20));
      end
      wait_idle(4000);
    end
    stray_ack = 0;

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Serial debug/loader bridge. It receives command frames on a UART rxd line and acts as a 16-bit bus initiator into the system memory map (RAM, UART registers). Read results and acknowledges go back on txd.
- It is the host-facing counterpart to the CPU-side memory-mapped UART. It lets an external PC load and inspect RAM while the CPU is held.
- Bus ownership uses a req/ack handshake with a top-level arbiter. The arbiter holds the CPU via clken.

Parameters:
- CLKSPEED, 32000000, clk frequency in Hz.
- BAUD, 115200, serial rate. Bit period DIV = CLKSPEED/BAUD, integer-truncated (277 at defaults).
- TIMEOUT_BITS, 2048, idle bit-periods mid-frame before the parser aborts to IDLE.

Ports:
- clk  input  1  system clock
- reset_b  input  1  asynchronous active-low reset
- rxd  input  1  serial in, 8N1, idle high; asynchronous to clk
- txd  output  1  serial out, 8N1, idle high
- bus_req  output  1  request bus ownership
- bus_ack  input  1  ownership granted; sampled on posedge clk
- bus_en  output  1  single-cycle access strobe
- address  output  16  bus address
- rnw  output  1  1 = read, 0 = write
- dout  output  16  write data
- din  input  16  read data; valid in the cycle bus_en is high
- busy  output  1  high whenever the parser is not in IDLE or the transmitter is active

Behaviour:
- Reset: asynchronous, active-low, clears all state. Output values in reset: txd=1, bus_req=0, bus_en=0, rnw=1, address=0, dout=0, busy=0. Reset mid-frame or mid-transmit abandons the operation; txd returns to 1 immediately.
- RX synchronisation: rxd passes through a 2-flop synchroniser before use.
- RX start detection: a falling edge starts the receiver. The line is re-checked at DIV/2; if high there, it is a glitch and the receiver returns to idle.
- RX sampling: data bits are sampled every DIV clocks, LSB first. The stop bit is sampled once.
- RX framing error: stop bit = 0 discards the byte and leaves the parser state unchanged. The receiver then waits for rxd high before re-arming.
- TX: a 1-byte holding register feeds the shifter. Each byte is sent as start, 8 data bits LSB first, stop; each bit lasts exactly DIV clocks.
- Reply sequencing: replies queue through the holding register. The parser never issues a second command until its reply bytes are fully handed to the transmitter.
- Parser states: IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, REQ, ACCESS, REPLY.
- IDLE on 0x57 'W': go to ADDR_H; after address, collect DATA_H, DATA_L, then REQ (write).
- IDLE on 0x52 'R': go to ADDR_H; after ADDR_L, go to REQ (read).
- IDLE on any other byte: send 0x3F '?' and stay in IDLE.
- REQ: assert bus_req and hold it while waiting on bus_ack. There is no limit on the wait.
- ACCESS: on the first clk with bus_req=1 and bus_ack=1, drive bus_en=1 for exactly one cycle with address/rnw/dout valid. On a read, capture din at the end of that cycle.
- After ACCESS: the next cycle, bus_en=0, bus_req=0, rnw=1.
- Latency: the bus_en cycle occurs 1 clk after the first sampled bus_ack=1.
- Bus outputs outside ACCESS: address and dout hold their last values.
- REPLY: a write sends 0x2E '.'; a read sends din[15:8] then din[7:0]. Then the parser returns to IDLE.
- Timeout: in ADDR_H..DATA_L, if no byte arrives within TIMEOUT_BITS*DIV clocks, return to IDLE silently. The counter restarts on every received byte.
- Bytes received in REQ, ACCESS or REPLY are dropped; there is no overrun reporting.
- bus_ack behaviour: bus_ack falling while bus_req is still high returns the parser to waiting in REQ. bus_ack high while bus_req=0 is ignored.

Test Plan:
1. Defaults (DIV=277): send 57 12 34 AB CD -> one bus_en pulse with address=0x1234, rnw=0, dout=0xABCD; txd returns 0x2E; no further bus_en.
2. Preload din=0xBEEF at 0x0040; send 52 00 40 -> bus_en with rnw=1, address=0x0040; txd returns BE then EF, each frame 10*277 clks.
3. Hold bus_ack=0 for 500 clks after bus_req rises -> bus_en stays 0 throughout; bus_en pulses exactly 1 clk after bus_ack goes high.
4. Send 0x41 -> txd 0x3F. Then send 52 00 with the stop bit forced 0 on the second byte, then 40 -> the bad byte is ignored; the read proceeds once the next valid byte completes ADDR_L.
5. Send 57 12 then idle for 2048*277+10 clks -> parser back in IDLE with busy=0; a following 52 00 40 performs a normal read.
6. Assert reset_b=0 mid-transmit of a read reply -> txd=1 and bus_req=0 immediately; after release, the next command operates normally.
